// File: rtl/riscv_ifetch.sv
// riscv_ifetch: instruction fetch stage between the PC stage and decode.
// Issues in-order word fetches under a credit limit of DEPTH (outstanding
// requests plus buffered instructions), tracks in-flight addresses in a small
// queue, buffers returned words with their PCs, and drops stale responses
// after a redirect flush (DRAIN state).
// Optional feature macro: RISCV_IFETCH_BYPASS_EN forwards a response straight
// to decode when the buffer is empty, the stage is running and decode is ready.
//
// Handshakes:
//   memory side: a request transfers when imem_req & imem_gnt; the stage then
//     pulses pc_advance. Responses (imem_rvalid) return in request order and
//     are always accepted.
//   decode side: if_valid/if_ready. An instruction transfers when
//     if_valid & if_ready. Once raised, if_valid and the head entry hold until
//     accepted or a flush clears the buffer.
module riscv_ifetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_out_cnt;
    logic [CW-1:0]   r_discard_cnt;
    logic [CW-1:0]   r_occ;
    logic [CW-1:0]   w_flush_discard;

    logic [31:0]     r_aq [DEPTH];
    logic [AW-1:0]   r_aq_wr_ptr;
    logic [AW-1:0]   r_aq_rd_ptr;

    logic [31:0]     r_buf_inst [DEPTH];
    logic [31:0]     r_buf_pc   [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;

    logic            w_credit;
    logic            w_grant;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;

    assign dbg_state = r_state;

    // Request side: combinational from state, counters, flush and grant only.
    assign w_credit   = ({1'b0, r_out_cnt} + {1'b0, r_occ}) < DEPTH_C;
    assign imem_req   = (r_state == ST_RUN) & ~flush & w_credit;
    assign imem_addr  = pc_in;
    assign w_grant    = imem_req & imem_gnt;
    assign pc_advance = w_grant;

    assign w_rsp           = imem_rvalid;
    assign w_flush_discard = r_out_cnt - {{(CW-1){1'b0}}, w_rsp};
    assign w_pop           = (r_occ != '0) & if_ready & ~flush;

`ifdef RISCV_IFETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass = (r_occ == '0) & (r_state == ST_RUN) & w_rsp & if_ready & ~flush;
    assign w_push   = w_rsp & (r_state == ST_RUN) & ~flush & ~w_bypass;
    assign if_valid = (r_occ != '0) | w_bypass;
    assign if_inst  = w_bypass ? imem_rdata : r_buf_inst[r_rd_ptr];
    assign if_pc    = w_bypass ? r_aq[r_aq_rd_ptr] : r_buf_pc[r_rd_ptr];
`else
    assign w_push   = w_rsp & (r_state == ST_RUN) & ~flush;
    assign if_valid = (r_occ != '0);
    assign if_inst  = r_buf_inst[r_rd_ptr];
    assign if_pc    = r_buf_pc[r_rd_ptr];
`endif

    // State register.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) r_state <= ST_BOOT;
        else          r_state <= w_state_nxt;
    end

    // Next state: BOOT lasts one cycle, DRAIN ends on the last stale response,
    // and a flush overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            ST_DRAIN: if (w_rsp && (r_discard_cnt == CW'(1))) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_BOOT;
        endcase
        if (flush) begin
            w_state_nxt = (w_flush_discard != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    // Outstanding and discard counters; a flush reloads both with the
    // responses still owed by memory after this cycle.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            r_out_cnt     <= '0;
            r_discard_cnt <= '0;
        end else if (flush) begin
            r_out_cnt     <= w_flush_discard;
            r_discard_cnt <= w_flush_discard;
        end else begin
            r_out_cnt <= r_out_cnt + {{(CW-1){1'b0}}, w_grant} - {{(CW-1){1'b0}}, w_rsp};
            if ((r_state == ST_DRAIN) && w_rsp) begin
                r_discard_cnt <= r_discard_cnt - CW'(1);
            end
        end
    end

    // In-flight address queue: push on grant, pop on every response
    // (kept or dropped), so it stays aligned with the memory's order.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            r_aq_wr_ptr <= '0;
            r_aq_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_aq[i] <= '0;
        end else begin
            if (w_grant) begin
                r_aq[r_aq_wr_ptr] <= pc_in;
                r_aq_wr_ptr       <= r_aq_wr_ptr + AW'(1);
            end
            if (w_rsp) begin
                r_aq_rd_ptr <= r_aq_rd_ptr + AW'(1);
            end
        end
    end

    // Instruction buffer: written by kept responses, popped by decode,
    // emptied by flush.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_inst[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_buf_inst[r_wr_ptr] <= imem_rdata;
                r_buf_pc[r_wr_ptr]   <= r_aq[r_aq_rd_ptr];
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_occ <= r_occ + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
        end
    end

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch (DEPTH = 2): a PC stage model that advances
// on pc_advance and loads a target on flush, and an in-order memory model with
// one-cycle latency that can hold its responses.
module tb_riscv_ifetch;

    logic        clk;
    logic        x_reset;
    logic [31:0] pc_in;
    logic        flush;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [1:0]  dbg_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] flush_target;
    logic        mem_hold;
    logic [31:0] pend_q[$];

    riscv_ifetch #(.DEPTH(2)) dut (
        .clk         (clk),
        .x_reset     (x_reset),
        .pc_in       (pc_in),
        .flush       (flush),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .dbg_state   (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // A response must never arrive while the buffer is full in RUN.
    always @(negedge clk) begin
        if (x_reset && imem_rvalid && (dbg_state == 2'd1) && !flush) begin
            assert (dut.r_occ < 2)
                else $error("FAIL buf_overrun: got occupancy %0d required < 2", dut.r_occ);
        end
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake, advance PC and memory models after the edge.
    task automatic tick();
        logic        g;
        logic        adv;
        logic        fl;
        logic [31:0] a;
        g   = imem_req & imem_gnt;
        adv = pc_advance;
        fl  = flush;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (fl)       pc_in = flush_target;
        else if (adv) pc_in = pc_in + 32'd1;
        flush = 1'b0;
        if (g) pend_q.push_back(a);
        if (!mem_hold && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(pend_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    // Asynchronous reset; outputs must clear without waiting for a clock.
    task automatic do_reset();
        x_reset = 1'b0;
        flush = 1'b0; imem_gnt = 1'b0; if_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pc_in = 32'h0; mem_hold = 1'b0; flush_target = 32'h0;
        pend_q.delete();
        #1;
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        x_reset = 1'b1;
        #1;
    endtask

    initial begin
        int n;
        int grants;
        x_reset = 1'b0; flush = 1'b0; imem_gnt = 1'b0; if_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; pc_in = 32'h0;
        mem_hold = 1'b0; flush_target = 32'h0;

        // Test 1: streaming fetch, in-order delivery of PCs 0..3.
        do_reset();
        check("rst_pc_advance", {31'b0, pc_advance}, 32'd0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        imem_gnt = 1'b1; if_ready = 1'b1;
        #1;
        check("boot_no_req", {31'b0, imem_req}, 32'd0);
        tick();
        check("run_state", {30'b0, dbg_state}, 32'd1);
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'd0);
        check("first_adv", {31'b0, pc_advance}, 32'd1);
        tick();
`ifdef RISCV_IFETCH_BYPASS_EN
        check("rsp_cycle_valid", {31'b0, if_valid}, 32'd1);
        check("rsp_cycle_inst", if_inst, 32'h00000013);
`else
        check("rsp_cycle_valid", {31'b0, if_valid}, 32'd0);
        tick();
        check("rsp_plus1_valid", {31'b0, if_valid}, 32'd1);
        check("rsp_plus1_inst", if_inst, 32'h00000013);
`endif
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            if (if_valid && if_ready) begin
                check("t1_if_pc", if_pc, n);
                check("t1_if_inst", if_inst, inst_of(n));
                n++;
            end
            if (n < 4) tick();
        end
        check("t1_accepts", n, 32'd4);

        // Test 2: decode stalled, credit limit stops requests at DEPTH.
        do_reset();
        imem_gnt = 1'b1; if_ready = 1'b0;
        #1;
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            if (imem_req && imem_gnt) grants++;
            tick();
        end
        check("t2_grants", grants, 32'd2);
        check("t2_req_off", {31'b0, imem_req}, 32'd0);
        check("t2_valid", {31'b0, if_valid}, 32'd1);
        check("t2_if_pc", if_pc, 32'd0);
        check("t2_if_inst", if_inst, 32'h00000013);
        if_ready = 1'b1;
        #1;
        tick();
        check("t2_resume_req", {31'b0, imem_req}, 32'd1);
        check("t2_resume_addr", imem_addr, 32'd2);
        check("t2_next_pc", if_pc, 32'd1);

        // Test 3: grant withheld, request holds steady.
        do_reset();
        imem_gnt = 1'b0; if_ready = 1'b1;
        #1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t3_req", {31'b0, imem_req}, 32'd1);
            check("t3_adv", {31'b0, pc_advance}, 32'd0);
            check("t3_addr", imem_addr, 32'd0);
            tick();
        end
        imem_gnt = 1'b1;
        #1;
        check("t3_adv_on_gnt", {31'b0, pc_advance}, 32'd1);

        // Test 4: flush with two outstanding, both responses dropped in DRAIN.
        do_reset();
        pc_in = 32'd4; imem_gnt = 1'b1; if_ready = 1'b1; mem_hold = 1'b1;
        #1;
        tick();
        check("t4_addr4", imem_addr, 32'd4);
        tick();
        check("t4_addr5", imem_addr, 32'd5);
        tick();
        check("t4_credit_full", {31'b0, imem_req}, 32'd0);
        flush = 1'b1; flush_target = 32'd20;
        #1;
        check("t4_flush_adv", {31'b0, pc_advance}, 32'd0);
        tick();
        check("t4_drain", {30'b0, dbg_state}, 32'd2);
        check("t4_drain_req", {31'b0, imem_req}, 32'd0);
        mem_hold = 1'b0;
        tick();
        check("t4_drop1_valid", {31'b0, if_valid}, 32'd0);
        check("t4_drop1_state", {30'b0, dbg_state}, 32'd2);
        tick();
        check("t4_drop2_valid", {31'b0, if_valid}, 32'd0);
        check("t4_drop2_req", {31'b0, imem_req}, 32'd0);
        tick();
        check("t4_run", {30'b0, dbg_state}, 32'd1);
        check("t4_new_req", {31'b0, imem_req}, 32'd1);
        check("t4_new_addr", imem_addr, 32'd20);
        for (int k = 0; k < 6 && !if_valid; k++) tick();
        check("t4_new_valid", {31'b0, if_valid}, 32'd1);
        check("t4_new_pc", if_pc, 32'd20);
        check("t4_new_inst", if_inst, inst_of(32'd20));

        // Test 5: flush coincident with a response and an offered grant.
        do_reset();
        imem_gnt = 1'b1; if_ready = 1'b1; mem_hold = 1'b1;
        #1;
        tick();
        tick();
        mem_hold = 1'b0;
        tick();
        check("t5_rsp_present", {31'b0, imem_rvalid}, 32'd1);
        flush = 1'b1; flush_target = 32'd40; mem_hold = 1'b1;
        #1;
        check("t5_no_req", {31'b0, imem_req}, 32'd0);
        check("t5_no_adv", {31'b0, pc_advance}, 32'd0);
        check("t5_no_valid", {31'b0, if_valid}, 32'd0);
        tick();
        check("t5_drain", {30'b0, dbg_state}, 32'd2);
        check("t5_dropped", {31'b0, if_valid}, 32'd0);
        mem_hold = 1'b0;
        tick();
        check("t5_last_drop_state", {30'b0, dbg_state}, 32'd2);
        check("t5_last_drop_valid", {31'b0, if_valid}, 32'd0);
        tick();
        check("t5_run", {30'b0, dbg_state}, 32'd1);
        check("t5_req", {31'b0, imem_req}, 32'd1);
        check("t5_addr", imem_addr, 32'd40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
